mem_initiator: RTL
==================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: RAM byte-address width.
REQ-002 Parameter DEPTH, default 16: number of RAM bytes; RAM data width is fixed at 8.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, listed as the first two ports below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  zero-extend load result (1) or sign-extend (0).
REQ-011 req_addr  in  ADDR_WIDTH  byte address.
REQ-012 req_wdata  in  32  store data, little-endian.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_error  out  1  request rejected; qualified by rsp_valid.
REQ-015 rsp_rdata  out  32  load result; 0 for stores and errors.
REQ-016 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-017 ram_data_in  out  8  RAM write data.
REQ-018 ram_read_enable  out  1  RAM read strobe.
REQ-019 ram_write_enable  out  1  RAM write strobe.
REQ-020 ram_data_out  in  8  RAM read data, valid one cycle after its read strobe (registered read).

Function
REQ-021 The FSM SHALL have states IDLE, XFER, DRAIN and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 A request SHALL be accepted at an edge where req_valid && req_ready; the request fields SHALL be latched at that edge, and C1 denotes the following cycle.
REQ-023 The byte count n SHALL be 1, 2 or 4 for req_size 00, 01 or 10, respectively.
REQ-024 An error SHALL be flagged when req_size is 11, or req_addr mod n != 0, or req_addr+n > DEPTH.
REQ-025 On error: rsp_valid=1, rsp_error=1 and rsp_rdata=0 in C1; no RAM strobe is asserted; the next state is IDLE.
REQ-026 Store: in cycle Ci (i = 1..n), ram_write_enable=1, ram_addr=req_addr+i-1 and ram_data_in=req_wdata[8(i-1)+7 : 8(i-1)].
REQ-027 Store response: rsp_valid=1 and rsp_error=0 in cycle Cn+1.
REQ-028 Load: in cycle Ci (i = 1..n), ram_read_enable=1 and ram_addr=req_addr+i-1; ram_data_out SHALL be captured at the end of Ci+1 into result byte i-1.
REQ-029 Load response: rsp_valid=1 in cycle Cn+2 (DRAIN covers Cn+1), with registered rsp_rdata.
REQ-030 Load extension: bits above 8n SHALL be replicated from bit 8n-1 when req_unsigned=0 and zeroed when req_unsigned=1; word loads are unaffected.
REQ-031 rsp_valid SHALL be high for exactly one cycle per accepted request; there is no response backpressure.
REQ-032 RESP SHALL always go to IDLE, so a new request can be accepted at the earliest at the edge ending the cycle after rsp_valid.
REQ-033 ram_read_enable and ram_write_enable SHALL never both be 1, and both SHALL be 0 outside XFER.
REQ-034 rsp_rdata and rsp_error SHALL be 0 whenever rsp_valid=0.
REQ-035 ram_addr never wraps, because out-of-range requests are rejected under REQ-024.

Reset
REQ-036 While rst=1, all outputs SHALL be 0 (including req_ready), the state SHALL be IDLE, and internal registers SHALL be cleared asynchronously.
REQ-037 Reset asserted mid-operation SHALL drop RAM strobes immediately; no response is issued for the aborted request.
REQ-038 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-039 SW 0xDEADBEEF @4 -> writes EF@4, BE@5, AD@6, DE@7 in C1..C4; rsp_valid in C5 with rsp_error=0 and rsp_rdata=0.
REQ-040 Then LW @4 -> reads @4..7 in C1..C4; rsp_valid in C6 with rsp_rdata=0xDEADBEEF.
REQ-041 Then LB @7 -> 0xFFFFFFDE; LBU @7 -> 0x000000DE; LH @6 -> 0xFFFFDEAD; LHU @6 -> 0x0000DEAD.
REQ-042 Each of LW @2, LH @5, req_size=11, and LW @16 (DEPTH=16) -> rsp_error=1 in C1 with no RAM strobe; LW @12 -> no error.
REQ-043 rst pulsed during C2 of SW @8 -> strobes 0 immediately, no rsp_valid, req_ready=1 after release, bytes @9..11 unchanged.
REQ-044 req_valid held high across a busy period -> req_ready=0 until IDLE; the second request is accepted one cycle after the first rsp_valid, with no overlap of RAM strobes.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: turns one byte/half/word load or store request into a
// sequence of single-byte accesses on an 8-bit RAM with registered reads.
// Each accepted request produces exactly one response pulse.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_size,           store/load, 00 byte 01 half 10 word 11 illegal,
//   req_unsigned                   zero- or sign-extend load result
//   req_addr, req_wdata            byte address, little-endian store data
//   rsp_valid, rsp_error,          one-cycle response pulse, reject flag,
//   rsp_rdata                      extended load data (0 otherwise)
//   ram_addr, ram_data_in,         RAM address and write data
//   ram_read_enable,               RAM read strobe (data returns next cycle)
//   ram_write_enable, ram_data_out RAM write strobe, RAM read data
module mem_initiator #(
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_error,
   output logic [31:0]           rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_data_in,
   output logic                  ram_read_enable,
   output logic                  ram_write_enable,
   input  logic [7:0]            ram_data_out
);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    write_q, uns_q, err_q;
   logic [1:0]              size_q, idx_q, idx_d, rd_idx_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic                    rd_pend_q;
   logic [3:0][7:0]         data_q;

   logic                    accept;
   logic [31:0]             n_in;
   logic                    err_in;
   logic [1:0]              last_idx;

   assign accept = req_valid && req_ready;

   // Legality of the incoming request, evaluated at acceptance.
   always_comb begin
      n_in = 32'd1;
      case (req_size)
         2'b01:   n_in = 32'd2;
         2'b10:   n_in = 32'd4;
         default: n_in = 32'd1;
      endcase
      err_in = (req_size == 2'b11)
            || ((32'(req_addr) & (n_in - 32'd1)) != 32'd0)
            || ((32'(req_addr) + n_in) > 32'(DEPTH));
   end

   always_comb begin
      case (size_q)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = err_in ? RESP : XFER;
            idx_d   = 2'd0;
         end
         XFER: begin
            idx_d = idx_q + 2'd1;
            if (idx_q == last_idx) state_d = write_q ? RESP : DRAIN;
         end
         DRAIN:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         write_q   <= 1'b0;
         uns_q     <= 1'b0;
         err_q     <= 1'b0;
         size_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         if (accept) begin
            write_q <= req_write;
            uns_q   <= req_unsigned;
            err_q   <= err_in;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= '0;
         end
         // RAM read is registered: byte requested in one cycle is on
         // ram_data_out during the next and captured at its end.
         rd_pend_q <= ram_read_enable;
         rd_idx_q  <= idx_q;
         if (rd_pend_q) data_q[rd_idx_q] <= ram_data_out;
      end
   end

   always_comb begin
      req_ready        = (state_q == IDLE) && !rst;
      ram_read_enable  = 1'b0;
      ram_write_enable = 1'b0;
      ram_addr         = '0;
      ram_data_in      = '0;
      rsp_valid        = 1'b0;
      rsp_error        = 1'b0;
      rsp_rdata        = '0;
      if (state_q == XFER) begin
         ram_write_enable = write_q;
         ram_read_enable  = !write_q;
         ram_addr         = addr_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q};
         if (write_q) ram_data_in = wdata_q[idx_q*8 +: 8];
      end
      if (state_q == RESP) begin
         rsp_valid = 1'b1;
         rsp_error = err_q;
         if (!err_q && !write_q) begin
            case (size_q)
               2'b00:   rsp_rdata = {{24{!uns_q && data_q[0][7]}}, data_q[0]};
               2'b01:   rsp_rdata = {{16{!uns_q && data_q[1][7]}}, data_q[1], data_q[0]};
               default: rsp_rdata = data_q;
            endcase
         end
      end
   end

endmodule
